// File: rtl/fetch_unit.sv
// Instruction fetch front-end: PC, single-outstanding imem requests, small
// instruction FIFO toward decode, and redirect with in-flight response discard.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] ir_pc
);

  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [31:0]   data_q [IBUF_DEPTH];
  logic [31:0]   data_d [IBUF_DEPTH];
  logic [31:0]   addr_q [IBUF_DEPTH];
  logic [31:0]   addr_d [IBUF_DEPTH];
  logic          has_room;
  logic          push;
  logic          pop;

  assign has_room = (count_q < CW'(IBUF_DEPTH));

  // A redirect abandons an unaccepted request, so it also masks req_valid.
  always_comb begin
    imem_req_valid = (state_q == S_REQ) && has_room && !redirect_valid && !reset;
    imem_req_addr  = pc_q;
    ir_valid       = (count_q != {CW{1'b0}});
    if (ir_valid) begin
      ir    = data_q[head_q];
      ir_pc = addr_q[head_q];
    end else begin
      ir    = 32'h0000_0000;
      ir_pc = 32'h0000_0000;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    data_d  = data_q;
    addr_d  = addr_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      count_d = {CW{1'b0}};
      head_d  = {PW{1'b0}};
      tail_d  = {PW{1'b0}};
      // Outstanding response still owed unless it lands this very cycle.
      if (state_q == S_REQ) begin
        state_d = S_REQ;
      end else if (imem_resp_valid) begin
        state_d = S_REQ;
      end else begin
        state_d = S_DROP;
      end
    end else begin
      pop = ir_valid && ir_ready;
      case (state_q)
        S_REQ: begin
          if (imem_req_valid && imem_req_ready) state_d = S_WAIT;
          else                                  state_d = S_REQ;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            push    = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = S_REQ;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_DROP: begin
          if (imem_resp_valid) state_d = S_REQ;
          else                 state_d = S_DROP;
        end
        default: state_d = S_REQ;
      endcase
      if (push) begin
        data_d[tail_q] = imem_resp_data;
        addr_d[tail_q] = pc_q;
        tail_d         = tail_q + PW'(1);
      end else begin
        tail_d = tail_q;
      end
      if (pop) head_d = head_q + PW'(1);
      else     head_d = head_q;
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State, PC and buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      count_q <= {CW{1'b0}};
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      for (int i = 0; i < IBUF_DEPTH; i++) begin
        data_q[i] <= 32'h0000_0000;
        addr_q[i] <= 32'h0000_0000;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: bench-side memory model pushes expected
// {word, pc} on each response; decode-side pops are compared in order.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ir_valid, ir_ready;
  logic [31:0] ir, ir_pc;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_resp_valid;
  logic [31:0] w_resp_data;
  logic        w_ir_valid;
  logic [31:0] w_ir, w_ir_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .IBUF_DEPTH(2)) u_dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir(ir), .ir_pc(ir_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .IBUF_DEPTH(2)) u_dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(w_req_addr), .imem_resp_valid(w_resp_valid),
    .imem_resp_data(w_resp_data), .redirect_valid(1'b0),
    .redirect_pc(32'h0000_0000), .ir_valid(w_ir_valid), .ir_ready(1'b1),
    .ir(w_ir), .ir_pc(w_ir_pc)
  );

  int          n_tests = 0;
  int          n_fail  = 0;

  bit          rst_v, rd_v, rdy, mem_rdy, prev_rd;
  logic [31:0] rd_pc;
  int          k, dly, pops, w_pops;
  bit          pend, pend_drop, acc, w_pend;
  logic [31:0] pend_addr, exp_pc, acc_addr, last_pop_pc, w_pend_addr, w_exp_pc;
  logic [63:0] sb_q [$];
  logic [63:0] w_q [$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return 32'h0000_00A0 + (a >> 2);
  endfunction

  // One clock: drive inputs at negedge, model memory, score pops and requests.
  task automatic step();
    logic        resp_now, resp_drop;
    logic [63:0] e;
    @(negedge clk);
    reset          = rst_v;
    redirect_valid = rd_v;
    redirect_pc    = rd_pc;
    ir_ready       = rdy;
    imem_req_ready = mem_rdy;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    resp_now  = 1'b0;
    resp_drop = 1'b0;
    if (pend && dly == 0) begin
      resp_now        = 1'b1;
      resp_drop       = pend_drop;
      imem_resp_valid = 1'b1;
      imem_resp_data  = pend_drop ? 32'hDEAD_BEEF : data_of(pend_addr);
      pend            = 1'b0;
    end else if (pend) begin
      dly--;
    end
    w_resp_valid = w_pend;
    w_resp_data  = w_pend ? ~w_pend_addr : 32'h0;
    #1;
    acc = 1'b0;
    if (prev_rd) check_eq("ir_valid_after_redirect", 32'(ir_valid), 32'h0);
    if (rd_v) begin
      sb_q.delete();
      exp_pc = {rd_pc[31:2], 2'b00};
      if (pend) pend_drop = 1'b1;
    end else begin
      if (ir_valid && rdy) begin
        if (sb_q.size() == 0) begin
          check_eq("ir_valid_when_empty", 32'(ir_valid), 32'h0);
        end else begin
          e = sb_q.pop_front();
          check_eq("ir", ir, e[63:32]);
          check_eq("ir_pc", ir_pc, e[31:0]);
          last_pop_pc = e[31:0];
          pops++;
        end
      end
      if (resp_now && !resp_drop) begin
        sb_q.push_back({imem_resp_data, exp_pc});
        exp_pc = exp_pc + 32'd4;
      end
    end
    if (imem_req_valid && mem_rdy) begin
      check_eq("single_outstanding", 32'(pend), 32'h0);
      check_eq("req_addr", imem_req_addr, exp_pc);
      acc       = 1'b1;
      acc_addr  = imem_req_addr;
      pend      = 1'b1;
      pend_drop = 1'b0;
      pend_addr = exp_pc;
      dly       = k - 1;
    end
    prev_rd = rd_v;
    if (w_ir_valid) begin
      if (w_q.size() == 0) begin
        check_eq("wrap_ir_valid_when_empty", 32'(w_ir_valid), 32'h0);
      end else begin
        e = w_q.pop_front();
        check_eq("wrap_ir", w_ir, e[63:32]);
        check_eq("wrap_ir_pc", w_ir_pc, e[31:0]);
        w_pops++;
      end
    end
    if (w_resp_valid) begin
      w_q.push_back({w_resp_data, w_exp_pc});
      w_exp_pc = w_exp_pc + 32'd4;
    end
    w_pend = 1'b0;
    if (w_req_valid) begin
      check_eq("wrap_req_addr", w_req_addr, w_exp_pc);
      w_pend      = 1'b1;
      w_pend_addr = w_exp_pc;
    end
  endtask

  initial begin
    int n;
    logic [31:0] held;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; ir_ready = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    w_resp_valid = 1'b0; w_resp_data = 32'h0;
    rst_v = 1'b1; rd_v = 1'b0; rd_pc = 32'h0; rdy = 1'b1; mem_rdy = 1'b1; prev_rd = 1'b0;
    k = 1; dly = 0; pend = 1'b0; pend_drop = 1'b0; pend_addr = 32'h0; exp_pc = 32'h0;
    acc = 1'b0; acc_addr = 32'h0; last_pop_pc = 32'h0; pops = 0;
    w_pend = 1'b0; w_pend_addr = 32'h0; w_exp_pc = 32'hFFFF_FFF8; w_pops = 0;

    repeat (2) step();
    check_eq("rst_ir_valid", 32'(ir_valid), 32'h0);
    check_eq("rst_ir", ir, 32'h0);
    check_eq("rst_ir_pc", ir_pc, 32'h0);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check_eq("rst_req_addr", imem_req_addr, 32'h0);
    check_eq("rst_wrap_req_addr", w_req_addr, 32'hFFFF_FFF8);
    check_eq("rst_wrap_req_valid", 32'(w_req_valid), 32'h0);
    rst_v = 1'b0;

    // Straight-line fetch: A0..A3 at 0,4,8,C.
    n = 0;
    while (pops < 4 && n < 40) begin step(); n++; end
    check_eq("t1_pops", 32'(pops), 32'd4);

    // Decode stalled: buffer fills to two, requests stop, resume at 8.
    rd_v = 1'b1; rd_pc = 32'h0; rdy = 1'b0; step(); rd_v = 1'b0;
    repeat (12) step();
    check_eq("stall_req_valid", 32'(imem_req_valid), 32'h0);
    check_eq("stall_ir_valid", 32'(ir_valid), 32'h1);
    check_eq("stall_head_pc", ir_pc, 32'h0);
    check_eq("stall_head_ir", ir, 32'h0000_00A0);
    rdy = 1'b1;
    n = 0;
    do begin step(); n++; end while (!acc && n < 20);
    check_eq("stall_resume_acc", 32'(acc), 32'h1);
    check_eq("stall_resume_addr", acc_addr, 32'h8);

    // Memory back-pressure: request held stable for 5 cycles.
    mem_rdy = 1'b0;
    rd_v = 1'b1; rd_pc = 32'h0; step(); rd_v = 1'b0;
    n = 0;
    do begin step(); n++; end while (!imem_req_valid && n < 10);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      check_eq("bp_req_valid", 32'(imem_req_valid), 32'h1);
      check_eq("bp_req_addr", imem_req_addr, 32'h0);
    end
    held = imem_req_addr;
    mem_rdy = 1'b1;
    step();
    check_eq("bp_accept", 32'(acc), 32'h1);
    check_eq("bp_accept_addr", acc_addr, held);

    // Redirect while waiting: late DEAD_BEEF response must be discarded.
    k = 2;
    n = 0;
    do begin step(); n++; end while (!acc && n < 10);
    rd_v = 1'b1; rd_pc = 32'h0000_0101; step(); rd_v = 1'b0;
    n = pops;
    for (int i = 0; i < 30 && pops == n; i++) step();
    check_eq("wait_redirect_first_pc", last_pop_pc, 32'h0000_0100);

    // Redirect coincident with response and pop, buffer non-empty.
    k = 1; rdy = 1'b0;
    n = 0;
    do begin step(); n++; end while (!(sb_q.size() >= 1 && pend && dly == 0) && n < 20);
    check_eq("rr_ir_valid_before", 32'(ir_valid), 32'h1);
    rdy = 1'b1; rd_v = 1'b1; rd_pc = 32'h0000_0200; step(); rd_v = 1'b0;
    step();
    check_eq("rr_req_valid", 32'(imem_req_valid), 32'h1);
    check_eq("rr_req_addr", imem_req_addr, 32'h0000_0200);

    n = 0;
    while ((sb_q.size() != 0 || pend) && n < 30) begin step(); n++; end
    check_eq("drain_empty", 32'(sb_q.size()), 32'h0);
    check_eq("wrap_min_pops", 32'(w_pops >= 3), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
